// File: rtl/sram_frame_arbiter.sv
// Shares one 16-bit asynchronous SRAM between a real-time reader and a pixel writer.
// Reads have priority. A streak counter forces one write after STARVE_LIMIT consecutive contended reads.
module sram_frame_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              Clk,
  input  logic              RESET_N,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [15:0]       rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ack,
  output logic              busy,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDRESS,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, TURN} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       wdata_reg;
  logic [1:0]        be_reg;
  logic [7:0]        streak_reg;
  logic              grant_point, wr_win, rd_win, dq_drive;

  always_comb begin
    grant_point = (state_reg == IDLE) || (state_reg == RD2) || (state_reg == WR2);
    wr_win      = grant_point && wr_req && (!rd_req || (streak_reg == LIMIT));
    rd_win      = grant_point && !wr_win && rd_req;
  end

  // Acks are masked during reset so nothing is granted into a state that is about to be cleared.
  assign rd_ack = RESET_N && rd_win;
  assign wr_ack = RESET_N && wr_win;
  assign busy   = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RD1:     state_next = RD2;
      WR1:     state_next = WR2;
      TURN:    state_next = WR1;
      default: begin
        if (wr_win)
          state_next = (state_reg == RD2) ? TURN : WR1;
        else if (rd_win)
          state_next = RD1;
        else
          state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!RESET_N) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      be_reg     <= '0;
      streak_reg <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rd_valid  <= (state_reg == RD2);
      if (state_reg == RD2)
        rd_data <= SRAM_DQ;
      if (wr_win) begin
        addr_reg  <= wr_addr;
        wdata_reg <= wr_data;
        be_reg    <= wr_be;
      end else if (rd_win) begin
        addr_reg <= rd_addr;
      end
      // Streak counts contended read grants; any idle-writer cycle or write grant restarts it.
      if (!wr_req || wr_win)
        streak_reg <= '0;
      else if (rd_win && (streak_reg != LIMIT))
        streak_reg <= streak_reg + 8'd1;
    end
  end

  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    dq_drive  = 1'b0;
    case (state_reg)
      RD1, RD2: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
      end
      WR1, WR2: begin
        SRAM_CE_N = 1'b0;
        SRAM_WE_N = (state_reg != WR1);
        SRAM_UB_N = ~be_reg[1];
        SRAM_LB_N = ~be_reg[0];
        dq_drive  = 1'b1;
      end
      default: ;
    endcase
  end

  // DQ is driven only in write states, where OE_N is always high.
  assign SRAM_DQ      = dq_drive ? wdata_reg : 16'hzzzz;
  assign SRAM_ADDRESS = addr_reg;

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Randomized bench for sram_frame_arbiter with an SRAM model and a cycle-schedule reference model.
// The reference predicts grants, strobes, write data and read returns from the arbitration rules.
module tb_sram_frame_arbiter;

  localparam int AW  = 10;
  localparam int LIM = 8;

  logic          Clk = 1'b0;
  logic          RESET_N;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [15:0]   wr_data;
  logic [1:0]    wr_be;
  logic          rd_ack, wr_ack, rd_valid, busy;
  logic [15:0]   rd_data;
  wire  [15:0]   dq;
  logic [AW-1:0] sram_addr;
  logic          ce_n, oe_n, we_n, ub_n, lb_n;

  always #5 Clk = ~Clk;

  sram_frame_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .Clk(Clk), .RESET_N(RESET_N),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
    .busy(busy), .SRAM_DQ(dq), .SRAM_ADDRESS(sram_addr),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  // Asynchronous SRAM model with a backdoor load port used only during reset.
  logic [15:0]   mem [0:(1<<AW)-1];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_val;

  assign dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;

  always @(posedge Clk) begin
    if (load_en)
      mem[load_addr] <= load_val;
    else if (!ce_n && !we_n) begin
      if (!ub_n) mem[sram_addr][15:8] <= dq[15:8];
      if (!lb_n) mem[sram_addr][7:0]  <= dq[7:0];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  // Reference model: per-cycle expectations scheduled at grant time.
  logic [15:0]   ref_mem [0:(1<<AW)-1];
  logic [4:0]    exp_str  [int];
  logic [15:0]   exp_val  [int];
  logic [15:0]   exp_dq   [int];
  logic [AW-1:0] exp_addr [int];
  int            free_at = 0;
  int            last_rd = -10;
  int            reads_in_row = 0;
  bit            rst_pending = 1'b1;

  always @(negedge Clk) begin
    bit        grant, ew, er;
    int        w1;
    logic [15:0] old;
    cyc++;
    if (load_en) ref_mem[load_addr] = load_val;
    if (!RESET_N) begin
      chk("rst_ack", {rd_ack, wr_ack}, 0);
      exp_str.delete(); exp_val.delete(); exp_dq.delete(); exp_addr.delete();
      reads_in_row = 0;
      rst_pending  = 1'b1;
    end else begin
      if (rst_pending) begin
        free_at     = cyc - 1;
        last_rd     = -10;
        rst_pending = 1'b0;
        chk("rst_addr", 32'(sram_addr), 0);
      end
      chk("strobe", {ce_n, oe_n, we_n, ub_n, lb_n}, exp_str.exists(cyc) ? exp_str[cyc] : 5'h1f);
      if (exp_addr.exists(cyc)) chk("addr", 32'(sram_addr), 32'(exp_addr[cyc]));
      if (exp_dq.exists(cyc))   chk("wr_dq", dq, exp_dq[cyc]);
      chk("rd_valid", rd_valid, exp_val.exists(cyc) ? 1 : 0);
      if (exp_val.exists(cyc))  chk("rd_data", rd_data, exp_val[cyc]);
      chk("busy", busy, (cyc <= free_at) ? 1 : 0);
      grant = (cyc >= free_at);
      ew    = grant && wr_req && (!rd_req || reads_in_row == LIM);
      er    = grant && !ew && rd_req;
      chk("ack", {rd_ack, wr_ack}, {er, ew});
      if (er) begin
        exp_str[cyc+1] = 5'b00100;  exp_str[cyc+2] = 5'b00100;
        exp_addr[cyc+1] = rd_addr;  exp_addr[cyc+2] = rd_addr;
        exp_val[cyc+3] = ref_mem[rd_addr];
        free_at = cyc + 2;
        last_rd = cyc;
      end
      if (ew) begin
        // A write granted in the second cycle of a read needs one turnaround cycle.
        w1 = cyc + 1 + ((last_rd == cyc - 2) ? 1 : 0);
        exp_str[w1]   = {3'b010, ~wr_be[1], ~wr_be[0]};
        exp_str[w1+1] = {3'b011, ~wr_be[1], ~wr_be[0]};
        exp_dq[w1] = wr_data;     exp_dq[w1+1] = wr_data;
        exp_addr[w1] = wr_addr;   exp_addr[w1+1] = wr_addr;
        old = ref_mem[wr_addr];
        ref_mem[wr_addr] = {wr_be[1] ? wr_data[15:8] : old[15:8], wr_be[0] ? wr_data[7:0] : old[7:0]};
        free_at = w1 + 1;
      end
      if (!wr_req || ew)
        reads_in_row = 0;
      else if (er && reads_in_row < LIM)
        reads_in_row++;
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [15:0] v);
    load_addr = a; load_val = v; load_en = 1'b1;
    @(posedge Clk); #1;
    load_en = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [15:0] d);
    bit ok = 1'b0;
    rd_addr = a; rd_req = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge Clk); if (rd_ack) ok = 1'b1; end
    @(posedge Clk); #1;
    rd_req = 1'b0;
    chk("rd_granted", ok, 1);
    ok = 1'b0; d = '0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge Clk);
      if (rd_valid) begin ok = 1'b1; d = rd_data; end
    end
    chk("rd_returned", ok, 1);
    @(posedge Clk); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
    bit ok = 1'b0;
    wr_addr = a; wr_data = d; wr_be = be; wr_req = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge Clk); if (wr_ack) ok = 1'b1; end
    @(posedge Clk); #1;
    wr_req = 1'b0;
    chk("wr_granted", ok, 1);
  endtask

  task automatic random_traffic(input int n, input int prd, input int pwr);
    bit ra, wa;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      ra = rd_ack; wa = wr_ack;
      @(posedge Clk); #1;
      if (ra) rd_req = 1'b0;
      if (wa) wr_req = 1'b0;
      if (!rd_req && $urandom_range(99) < prd) begin
        rd_req = 1'b1; rd_addr = 10'($urandom_range(15));
      end
      if (!wr_req && $urandom_range(99) < pwr) begin
        wr_req = 1'b1; wr_addr = 10'($urandom_range(15));
        wr_data = 16'($urandom); wr_be = 2'($urandom_range(3));
      end
    end
    @(posedge Clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    int          n, gap;
    bit          ok;
    RESET_N = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    load_en = 1'b0; load_addr = '0; load_val = '0;
    repeat (2) begin @(posedge Clk); #1; chk("rst_acks", {rd_ack, wr_ack}, 0); end
    chk("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1f);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    rd_req = 1'b0; wr_req = 1'b0;
    for (int i = 0; i < 16; i++) preload(10'(i), 16'($urandom));
    preload(10'd5, 16'h0034);
    preload(10'h123, 16'hBEEF);
    RESET_N = 1'b1;

    do_read(10'h123, got);
    chk("read_beef", got, 16'hBEEF);

    do_write(10'd5, 16'hAB12, 2'b10);
    do_read(10'd5, got);
    chk("byte_write", got, 16'hAB34);

    // Both requesters held high: the writer gets in after exactly LIM reads, twice.
    rd_req = 1'b1; rd_addr = 10'd2;
    wr_req = 1'b1; wr_addr = 10'd3; wr_data = 16'h5A5A; wr_be = 2'b11;
    for (int r = 0; r < 2; r++) begin
      n = 0; ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge Clk);
        if (wr_ack) ok = 1'b1;
        else if (rd_ack) n++;
      end
      chk("starve_write", ok, 1);
      chk("starve_reads", n, LIM);
    end
    @(posedge Clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (4) @(posedge Clk);
    #1;

    // Write then read with no idle cycle between them.
    do_write(10'd8, 16'hC3E1, 2'b11);
    rd_req = 1'b1; rd_addr = 10'd8; gap = 1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge Clk);
      if (rd_ack) ok = 1'b1; else gap++;
    end
    chk("wr_rd_gap", gap, 2);
    @(posedge Clk); #1;
    rd_req = 1'b0; ok = 1'b0; got = '0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge Clk);
      if (rd_valid) begin ok = 1'b1; got = rd_data; end
    end
    chk("wr_rd_data", got, 16'hC3E1);
    repeat (3) @(posedge Clk);
    #1;

    // Reset asserted during WR1.
    wr_addr = 10'h200; wr_data = 16'h1111; wr_be = 2'b11; wr_req = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge Clk); if (wr_ack) ok = 1'b1; end
    chk("wr1_granted", ok, 1);
    @(posedge Clk); #1;
    wr_req = 1'b0;
    chk("in_wr1", we_n, 0);
    RESET_N = 1'b0;
    @(posedge Clk); #1;
    chk("wr1_rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1f);
    chk("wr1_rst_busy", busy, 0);
    chk("wr1_rst_valid", rd_valid, 0);
    RESET_N = 1'b1; rd_req = 1'b1; rd_addr = 10'd4;
    @(negedge Clk);
    chk("post_rst_ack", rd_ack, 1);
    @(posedge Clk); #1;
    rd_req = 1'b0;
    repeat (4) @(posedge Clk);
    #1;

    random_traffic(600, 50, 50);
    random_traffic(600, 90, 90);
    random_traffic(500, 20, 80);
    random_traffic(500, 100, 30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
